// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register and register-file writeback.
//   Captures one instruction per mem_valid/mem_ready handshake, aligns and
//   extends load data at capture, and commits it to the register file in the
//   cycle it leaves WB. It also counts retired instructions.
//   Optional feature macro: MEMWB_FWD_EN adds same-cycle forwarding hit outputs.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   mem_valid / mem_ready        handshake from MEM (ready = !wb_valid | !wb_stall)
//   mem_reg_write, mem_mem_to_reg, mem_load_type, mem_addr_lo,
//   mem_alu_result, mem_read_data, mem_rd   instruction fields from MEM
//   wb_stall, flush              hold / kill controls
//   reg_write, write_reg, write_data        register-file write port
//   wb_valid                     WB holds a live instruction
//   retire_count                 instructions that left WB since reset
//   id_rs, id_rt, fwd_rs_hit, fwd_rt_hit, fwd_data   (MEMWB_FWD_EN only)
module mem_wb_stage #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic              mem_reg_write,
    input  logic              mem_mem_to_reg,
    input  logic [2:0]        mem_load_type,
    input  logic [1:0]        mem_addr_lo,
    input  logic [31:0]       mem_alu_result,
    input  logic [31:0]       mem_read_data,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_stall,
    input  logic              flush,
`ifdef MEMWB_FWD_EN
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    output logic              fwd_rs_hit,
    output logic              fwd_rt_hit,
    output logic [31:0]       fwd_data,
`endif
    output logic              reg_write,
    output logic [REG_AW-1:0] write_reg,
    output logic [31:0]       write_data,
    output logic              wb_valid,
    output logic [CNT_W-1:0]  retire_count
);

    logic        rw_flag;
    logic        capture;
    logic        retire;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic [31:0] next_data;

    assign mem_ready = !wb_valid || !wb_stall;
    assign capture   = mem_valid && mem_ready && !flush;
    assign retire    = wb_valid && !wb_stall && !flush;
    // r0 is hard-wired zero, so a write to it is suppressed but still retires.
    assign reg_write = retire && rw_flag && (write_reg != '0);

    // Halfword selection uses only addr_lo[1]; addr_lo[0] is ignored.
    always_comb begin
        ld_byte   = mem_read_data[{mem_addr_lo, 3'b000} +: 8];
        ld_half   = mem_read_data[{mem_addr_lo[1], 4'b0000} +: 16];
        load_data = (mem_load_type == 3'b001) ? {{24{ld_byte[7]}}, ld_byte} :
                    (mem_load_type == 3'b010) ? {24'h0, ld_byte} :
                    (mem_load_type == 3'b011) ? {{16{ld_half[15]}}, ld_half} :
                    (mem_load_type == 3'b100) ? {16'h0, ld_half} :
                                                mem_read_data;
        next_data = mem_mem_to_reg ? load_data : mem_alu_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid     <= 1'b0;
            rw_flag      <= 1'b0;
            write_reg    <= '0;
            write_data   <= '0;
            retire_count <= '0;
        end else begin
            // Flush wins over capture; a retire with no capture empties WB.
            wb_valid <= !flush && (capture || (wb_valid && wb_stall));
            if (capture) begin
                rw_flag    <= mem_reg_write;
                write_reg  <= mem_rd;
                write_data <= next_data;
            end
            if (retire)
                retire_count <= retire_count + CNT_W'(1);
        end
    end

`ifdef MEMWB_FWD_EN
    assign fwd_rs_hit = reg_write && (write_reg == id_rs);
    assign fwd_rt_hit = reg_write && (write_reg == id_rt);
    assign fwd_data   = write_data;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: self-checking bench for mem_wb_stage.
//   Directed cases for ALU, loads, r0, stall and flush, then randomized
//   traffic compared against a transaction-level model of the WB slot.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic        mem_reg_write = 1'b0;
    logic        mem_mem_to_reg = 1'b0;
    logic [2:0]  mem_load_type = '0;
    logic [1:0]  mem_addr_lo = '0;
    logic [31:0] mem_alu_result = '0;
    logic [31:0] mem_read_data = '0;
    logic [4:0]  mem_rd = '0;
    logic        wb_stall = 1'b0;
    logic        flush = 1'b0;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        wb_valid;
    logic [31:0] retire_count;
`ifdef MEMWB_FWD_EN
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        fwd_rs_hit;
    logic        fwd_rt_hit;
    logic [31:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    // Model: the single WB slot as a record, plus the retire total.
    bit          m_valid;
    bit          m_rw;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [31:0] m_cnt;

    mem_wb_stage dut (
        .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
        .mem_load_type(mem_load_type), .mem_addr_lo(mem_addr_lo),
        .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
        .mem_rd(mem_rd), .wb_stall(wb_stall), .flush(flush),
`ifdef MEMWB_FWD_EN
        .id_rs(id_rs), .id_rt(id_rt), .fwd_rs_hit(fwd_rs_hit),
        .fwd_rt_hit(fwd_rt_hit), .fwd_data(fwd_data),
`endif
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .wb_valid(wb_valid), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Load result from the memory word using plain shifts and arithmetic.
    function automatic logic [31:0] model_load(input int lt, input int lo, input logic [31:0] w);
        int unsigned b = (w >> (8 * lo)) % 256;
        int unsigned h = (w >> (16 * (lo / 2))) % 65536;
        case (lt)
            1: return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
            2: return 32'(b);
            3: return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
            4: return 32'(h);
            default: return w;
        endcase
    endfunction

    // Compare every output against the model, then advance one clock.
    task automatic step();
        bit exp_ready, exp_we, ret, cap;
        #1;
        exp_ready = !m_valid || !wb_stall;
        ret       = m_valid && !wb_stall && !flush;
        exp_we    = ret && m_rw && m_rd != 0;
        cap       = mem_valid && exp_ready && !flush;
        check("mem_ready", 32'(mem_ready), 32'(exp_ready));
        check("reg_write", 32'(reg_write), 32'(exp_we));
        check("wb_valid", 32'(wb_valid), 32'(m_valid));
        check("write_reg", 32'(write_reg), 32'(m_rd));
        check("write_data", write_data, m_data);
        check("retire_count", retire_count, m_cnt);
`ifdef MEMWB_FWD_EN
        check("fwd_rs_hit", 32'(fwd_rs_hit), 32'(exp_we && m_rd == id_rs));
        check("fwd_rt_hit", 32'(fwd_rt_hit), 32'(exp_we && m_rd == id_rt));
        check("fwd_data", fwd_data, m_data);
`endif
        if (ret) m_cnt++;
        if (cap) begin
            m_rw   = mem_reg_write;
            m_rd   = mem_rd;
            m_data = mem_mem_to_reg ? model_load(int'(mem_load_type), int'(mem_addr_lo), mem_read_data)
                                    : mem_alu_result;
        end
        m_valid = !flush && (cap || (m_valid && !ret));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input bit v, input bit rw, input bit m2r, input logic [2:0] lt,
                         input logic [1:0] lo, input logic [31:0] alu, input logic [31:0] rd_w,
                         input logic [4:0] rd, input bit st, input bit fl);
        mem_valid = v; mem_reg_write = rw; mem_mem_to_reg = m2r; mem_load_type = lt;
        mem_addr_lo = lo; mem_alu_result = alu; mem_read_data = rd_w; mem_rd = rd;
        wb_stall = st; flush = fl;
        step();
    endtask

    task automatic idle(input bit st, input bit fl);
        issue(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, st, fl);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_reg_write", 32'(reg_write), 0);
        check("rst_wb_valid", 32'(wb_valid), 0);
        check("rst_write_data", write_data, 0);
        check("rst_retire_count", retire_count, 0);
        m_valid = 0; m_rw = 0; m_rd = 0; m_data = 0; m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        m_valid = 0; m_rw = 0; m_rd = 0; m_data = 0; m_cnt = 0;
        @(negedge clk);
        do_reset();
        idle(0, 0);

        issue(1, 1, 0, 0, 0, 32'h1234_5678, 32'h0, 5, 0, 0);
        check("alu_data", write_data, 32'h1234_5678);
        check("alu_we", 32'(reg_write), 1);
        idle(0, 0);
        check("alu_count", retire_count, 1);

        issue(1, 1, 1, 3'b001, 2'd3, 32'h0, 32'h80FF_7F01, 1, 0, 0);
        check("lb3", write_data, 32'hFFFF_FF80);
        issue(1, 1, 1, 3'b010, 2'd3, 32'h0, 32'h80FF_7F01, 2, 0, 0);
        check("lbu3", write_data, 32'h0000_0080);
        issue(1, 1, 1, 3'b011, 2'd2, 32'h0, 32'h80FF_7F01, 3, 0, 0);
        check("lh2", write_data, 32'hFFFF_80FF);
        issue(1, 1, 1, 3'b100, 2'd0, 32'h0, 32'h80FF_7F01, 4, 0, 0);
        check("lhu0", write_data, 32'h0000_7F01);
        idle(0, 0);

        issue(1, 1, 0, 0, 0, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
        check("r0_we", 32'(reg_write), 0);
        idle(0, 0);
        check("r0_count", retire_count, 6);

        issue(1, 1, 0, 0, 0, 32'h0000_0077, 32'h0, 7, 0, 0);
        for (int i = 0; i < 3; i++) begin
            issue(1, 1, 0, 0, 0, 32'h0000_0099, 32'h0, 9, 1, 0);
            check("stall_ready", 32'(mem_ready), 0);
        end
        check("stall_held_data", write_data, 32'h0000_0077);
        idle(0, 0);
        check("stall_one_write", retire_count, 7);

        issue(1, 1, 0, 0, 0, 32'h0000_0055, 32'h0, 8, 0, 0);
        idle(1, 0);
        idle(1, 1);
        check("flush_valid", 32'(wb_valid), 0);
        check("flush_count", retire_count, 7);
        idle(0, 0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                continue;
            end
`ifdef MEMWB_FWD_EN
            id_rs = 5'($urandom); id_rt = $urandom_range(0, 3) == 0 ? m_rd : 5'($urandom);
`endif
            issue($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 3'($urandom),
                  2'($urandom), $urandom, $urandom, 5'($urandom_range(0, 7)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
